// File: rtl/dmem_if.sv
// Load/store bus between the core's memory stage (master) and the data-memory
// responder (slave). `err` exists only when DMEM_MISALIGN_CHECK_EN is defined.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        sw;
   logic        sh;
   logic        sb;
   logic        lw;
   logic        lh;
   logic        lb;
   logic        rsp_valid;
   logic [31:0] rdata;
   logic        stall_M;
`ifdef DMEM_MISALIGN_CHECK_EN
   logic        err;
`endif

`ifdef DMEM_MISALIGN_CHECK_EN
   modport master (
      output req_valid, addr, wdata, sw, sh, sb, lw, lh, lb,
      input  req_ready, rsp_valid, rdata, stall_M, err
   );
   modport slave (
      input  req_valid, addr, wdata, sw, sh, sb, lw, lh, lb,
      output req_ready, rsp_valid, rdata, stall_M, err
   );
`else
   modport master (
      output req_valid, addr, wdata, sw, sh, sb, lw, lh, lb,
      input  req_ready, rsp_valid, rdata, stall_M
   );
   modport slave (
      input  req_valid, addr, wdata, sw, sh, sb, lw, lh, lb,
      output req_ready, rsp_valid, rdata, stall_M
   );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian array serving one
// load/store per handshake, responding a fixed LATENCY cycles after accept.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (misaligned accesses flag
// `err` instead of being force-aligned).
module dmem_responder #(
   parameter int unsigned ADDR_WIDTH = 17,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LATENCY    = 2
) (
   input logic   clk,
   input logic   rst,
   dmem_if.slave bus
);

   if (DATA_WIDTH != 32 || LATENCY < 1 || LATENCY > 15) begin : gen_bad_param
      $error("dmem_responder: DATA_WIDTH must be 32 and LATENCY in 1..15");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    pend_load_q, pend_load_d;
   logic                    pend_err_q, pend_err_d;
   logic [31:0]             pend_data_q, pend_data_d;
   logic [31:0]             rdata_q, rdata_d;

   logic                    resp_entry, resp_load, resp_err;
   logic [31:0]             resp_data;

   logic [5:0]              strobes;
   logic                    is_store, is_load, is_word, is_half;
   logic                    accept, mis;
   logic [ADDR_WIDTH-1:0]   a_raw, a0, a1, a2, a3;
   logic [7:0]              b0, b1, b2, b3;
   logic [31:0]             load_fmt;

   logic [7:0]              mem [2**ADDR_WIDTH];

   // Address bits above ADDR_WIDTH are intentionally ignored (address wraps).
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH];

   assign strobes  = {bus.sw, bus.sh, bus.sb, bus.lw, bus.lh, bus.lb};
   assign is_store = bus.sw | bus.sh | bus.sb;
   assign is_load  = bus.lw | bus.lh | bus.lb;
   assign is_word  = bus.sw | bus.lw;
   assign is_half  = bus.sh | bus.lh;
   assign accept   = bus.req_valid && bus.req_ready && $onehot(strobes);
   assign a_raw    = bus.addr[ADDR_WIDTH-1:0];

`ifdef DMEM_MISALIGN_CHECK_EN
   assign mis = (is_half & a_raw[0]) | (is_word & (|a_raw[1:0]));
   assign a0  = a_raw;
`else
   assign mis = 1'b0;
   // Without the checker, half/word accesses are silently aligned down.
   always_comb begin
      a0 = a_raw;
      if (is_word) begin
         a0[1:0] = 2'b00;
      end else if (is_half) begin
         a0[0] = 1'b0;
      end
   end
`endif

   assign a1 = a0 + ADDR_WIDTH'(1);
   assign a2 = a0 + ADDR_WIDTH'(2);
   assign a3 = a0 + ADDR_WIDTH'(3);
   assign b0 = mem[a0];
   assign b1 = mem[a1];
   assign b2 = mem[a2];
   assign b3 = mem[a3];

   // Format the load result from the array as it stands at the accept edge.
   always_comb begin
      load_fmt = {b3, b2, b1, b0};
      if (bus.lb) begin
         load_fmt = {{24{b0[7]}}, b0};
      end else if (bus.lh) begin
         load_fmt = {{16{b1[7]}}, b1, b0};
      end
   end

   // Commit store bytes at the accept edge; the array is never cleared.
   always_ff @(posedge clk) begin
      if (accept && is_store && !mis) begin
         mem[a0] <= bus.wdata[7:0];
         if (bus.sh || bus.sw) begin
            mem[a1] <= bus.wdata[15:8];
         end
         if (bus.sw) begin
            mem[a2] <= bus.wdata[23:16];
            mem[a3] <= bus.wdata[31:24];
         end
      end
   end

   // Next-state logic; resp_* describe the response being entered this edge.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_load_d = pend_load_q;
      pend_err_d  = pend_err_q;
      pend_data_d = pend_data_q;
      resp_entry  = 1'b0;
      resp_load   = 1'b0;
      resp_err    = 1'b0;
      resp_data   = pend_data_q;
      unique case (state_q)
         StIdle, StResp: begin
            state_d = StIdle;
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d    = StResp;
                  resp_entry = 1'b1;
                  resp_load  = is_load;
                  resp_err   = mis;
                  resp_data  = load_fmt;
               end else begin
                  state_d     = StBusy;
                  cnt_d       = 4'(LATENCY - 1);
                  pend_load_d = is_load;
                  pend_err_d  = mis;
                  pend_data_d = load_fmt;
               end
            end
         end
         StBusy: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = StResp;
               resp_entry = 1'b1;
               resp_load  = pend_load_q;
               resp_err   = pend_err_q;
               resp_data  = pend_data_q;
            end
         end
         default: state_d = StIdle;
      endcase
      rdata_d = (resp_entry && resp_load && !resp_err) ? resp_data : rdata_q;
   end

   // State and response registers; reset drops any pending response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         pend_load_q <= 1'b0;
         pend_err_q  <= 1'b0;
         pend_data_q <= 32'd0;
         rdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_load_q <= pend_load_d;
         pend_err_q  <= pend_err_d;
         pend_data_q <= pend_data_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   logic err_q;

   // Misalignment flag, raised only for the RESP cycle of the offending access.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= resp_entry && resp_err;
      end
   end

   assign bus.err = err_q;
`endif

   assign bus.req_ready = !rst && (state_q != StBusy);
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.stall_M   = (state_q == StBusy);
   assign bus.rdata     = rdata_q;

endmodule
